// File: rtl/memory_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// memory_port_arbiter_if
// Bundles the fetch request port, the load/store request port and the
// single-port memory command/response port of memory_port_arbiter.
//
// Signals:
//   ifReq/ifAddr            fetch read request and address
//   ifAck/ifData            fetch acknowledge pulse and fetched word
//   dReadReq/dWriteReq      load / store request from the control decode
//   dAddr/dWriteData        load/store address and store data
//   dAck/dReadData          load/store acknowledge pulse and load data
//   memEn/memWe             memory command strobe and write enable
//   memAddr/memWData        memory command address and write data
//   memRData                memory read data
//   stallF                  pipeline stall
//
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding pipeline plus memory macro (or a testbench)
// -----------------------------------------------------------------------------
interface memory_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ifReq;
  logic [ADDR_W-1:0] ifAddr;
  logic              ifAck;
  logic [DATA_W-1:0] ifData;
  logic              dReadReq;
  logic              dWriteReq;
  logic [ADDR_W-1:0] dAddr;
  logic [DATA_W-1:0] dWriteData;
  logic              dAck;
  logic [DATA_W-1:0] dReadData;
  logic              memEn;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWData;
  logic [DATA_W-1:0] memRData;
  logic              stallF;

  modport slave (
    input  ifReq, ifAddr, dReadReq, dWriteReq, dAddr, dWriteData, memRData,
    output ifAck, ifData, dAck, dReadData, memEn, memWe, memAddr, memWData,
           stallF
  );

  modport master (
    output ifReq, ifAddr, dReadReq, dWriteReq, dAddr, dWriteData, memRData,
    input  ifAck, ifData, dAck, dReadData, memEn, memWe, memAddr, memWData,
           stallF
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// -----------------------------------------------------------------------------
// memory_port_arbiter
// Shares one single-port synchronous memory between instruction fetch and the
// load/store path. Each request is latched in IDLE, exactly one memory command
// is issued, the fixed read latency is counted out, and the result is returned
// with a one-cycle acknowledge. stallF is high while any request is unacked.
//
// Parameters:
//   ADDR_W       address width
//   DATA_W       data width
//   MEM_LATENCY  cycles from the memEn cycle to valid memRData (1..15)
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   bus          memory_port_arbiter_if.slave (request, response, memory)
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin between fetch and data
//                  undefined -> fixed priority, data over fetch
// -----------------------------------------------------------------------------
module memory_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input logic                   clock,
  input logic                   reset,
  memory_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t            r_state;
  logic              r_grant_d;     // 1: data port owns the current command
  logic              r_is_write;
  logic [3:0]        r_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_ack;
  logic              r_d_ack;
  logic [DATA_W-1:0] r_if_data;
  logic [DATA_W-1:0] r_d_data;

  logic w_d_req;
  logic w_any_req;
  logic w_pick_d;
  logic w_pick_wr;

  assign w_d_req   = bus.dReadReq | bus.dWriteReq;
  assign w_any_req = bus.ifReq | w_d_req;
  // Read and write together is treated as a write.
  assign w_pick_wr = w_pick_d & bus.dWriteReq;

`ifdef MEM_ARB_RR_EN
  // 1: the most recent grant went to the data port.
  logic r_last_grant_d;

  // Under contention the requester that was not granted last wins.
  assign w_pick_d = w_d_req & (~bus.ifReq | ~r_last_grant_d);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_grant_d <= 1'b1;
    end else if (r_state == IDLE && w_any_req) begin
      r_last_grant_d <= w_pick_d;
    end
  end
`else
  // Fixed priority: the MEM-stage access is older than the fetch.
  assign w_pick_d = w_d_req;
`endif

  // NOTE: every register here is written with <= so all state updates
  // see the pre-edge values, regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_grant_d   <= 1'b0;
      r_is_write  <= 1'b0;
      r_cnt       <= 4'd0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_if_data   <= '0;
      r_d_data    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state     <= ISSUE;
            r_grant_d   <= w_pick_d;
            r_is_write  <= w_pick_wr;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_pick_wr;
            r_mem_addr  <= w_pick_d ? bus.dAddr : bus.ifAddr;
            r_mem_wdata <= bus.dWriteData;
          end
        end

        ISSUE: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          if (r_is_write) begin
            // Only the data port writes, so the ack goes to data.
            r_state <= RESP;
            r_d_ack <= 1'b1;
          end else begin
            r_state <= WAIT;
            r_cnt   <= 4'(MEM_LATENCY);
          end
        end

        WAIT: begin
          // The cycle whose count is 1 is the cycle memRData is valid, so
          // capture on the edge that takes the counter to 0.
          if (r_cnt <= 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= RESP;
            if (r_grant_d) begin
              r_d_data <= bus.memRData;
              r_d_ack  <= 1'b1;
            end else begin
              r_if_data <= bus.memRData;
              r_if_ack  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        RESP: begin
          // Always pass through IDLE so the requester can drop its request.
          r_state  <= IDLE;
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.memEn     = r_mem_en;
  assign bus.memWe     = r_mem_we;
  assign bus.memAddr   = r_mem_addr;
  assign bus.memWData  = r_mem_wdata;
  assign bus.ifAck     = r_if_ack;
  assign bus.ifData    = r_if_data;
  assign bus.dAck      = r_d_ack;
  assign bus.dReadData = r_d_data;

  // Combinational so the pipeline freezes in the same cycle a request
  // appears; held low while reset is asserted.
  assign bus.stallF = ~reset &
                      ((bus.ifReq & ~r_if_ack) | (w_d_req & ~r_d_ack));

endmodule

// File: tb/tb_memory_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_port_arbiter
// Self-checking bench for memory_port_arbiter. A behavioural memory drives
// memRData with the configured latency (and random junk otherwise). A
// transaction-level reference model predicts grant order, command cycles,
// ack cycles, returned data and the stall window of each request group.
// Cycle numbers are counted from the cycle the requests are first driven.
// -----------------------------------------------------------------------------
module tb_memory_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int L      = 2;
  localparam int MAX_K  = 64;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  memory_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  memory_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(L)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp;
  int n_err;

  // Default contents of a never-written word.
  function automatic logic [31:0] init_word(input logic [7:0] i);
    if (i == 8'h10) return 32'hDEADBEEF;
    return {i, ~i, i ^ 8'h5A, 8'h3C};
  endfunction

  // ---------------- memory macro model ----------------
  bit [31:0]   mem_val [256];
  bit          mem_wr  [256];
  logic [31:0] rd_pipe [L];

  always @(posedge clock) begin
    if (bus.memEn && bus.memWe) begin
      mem_val[bus.memAddr[9:2]] <= bus.memWData;
      mem_wr[bus.memAddr[9:2]]  <= 1'b1;
    end
    if (bus.memEn && !bus.memWe)
      rd_pipe[0] <= mem_wr[bus.memAddr[9:2]] ? mem_val[bus.memAddr[9:2]]
                                             : init_word(bus.memAddr[9:2]);
    else
      rd_pipe[0] <= $urandom();
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign bus.memRData = rd_pipe[L-1];

  // ---------------- reference model ----------------
  bit [31:0]   ex_val [256];
  bit          ex_wr  [256];
  int          m_if_k, m_d_k, m_last_k, m_en_n;
  int          m_en_k    [2];
  logic [31:0] m_en_addr [2];
  logic [31:0] m_en_wd   [2];
  bit          m_en_we   [2];
  logic [31:0] m_if_data, m_d_data;
  bit          m_last_d;

  task automatic model_reset();
    m_last_d  = 1'b1;
    m_if_data = '0;
    m_d_data  = '0;
  endtask

  task automatic model_txn(input bit r_if, input bit r_rd, input bit r_wr,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] wd);
    bit          d_req, d_first, take_d, active;
    int          done, issue_k;
    logic [7:0]  idx;
    logic [31:0] rd;
    d_req   = r_rd | r_wr;
    d_first = d_req;
    if (r_if && d_req) begin
`ifdef MEM_ARB_RR_EN
      d_first = !m_last_d;
`else
      d_first = 1'b1;
`endif
    end
    m_if_k = -1; m_d_k = -1; m_en_n = 0; done = 0;
    for (int g = 0; g < 2; g++) begin
      take_d = (g == 0) ? d_first : !d_first;
      active = take_d ? d_req : r_if;
      if (active) begin
        issue_k = (m_en_n == 0) ? 1 : done + 2;
        m_en_k[m_en_n]    = issue_k;
        m_en_addr[m_en_n] = take_d ? da : ia;
        m_en_we[m_en_n]   = take_d && r_wr;
        m_en_wd[m_en_n]   = wd;
        m_en_n++;
        idx = take_d ? da[9:2] : ia[9:2];
        if (take_d && r_wr) begin
          ex_val[idx] = wd;
          ex_wr[idx]  = 1'b1;
          done        = issue_k + 1;
          m_d_k       = done;
        end else begin
          rd   = ex_wr[idx] ? ex_val[idx] : init_word(idx);
          done = issue_k + 1 + L;
          if (take_d) begin m_d_data  = rd; m_d_k  = done; end
          else        begin m_if_data = rd; m_if_k = done; end
        end
        m_last_d = take_d;
      end
    end
    m_last_k = done;
  endtask

  // ---------------- stimulus driver / observer ----------------
  int          obs_en_n, obs_if_k, obs_d_k, obs_if_n, obs_d_n, obs_len;
  int          obs_en_k    [4];
  logic [31:0] obs_en_addr [4];
  logic [31:0] obs_en_wd   [4];
  logic        obs_en_we   [4];
  logic [31:0] obs_if_data, obs_d_data, obs_if_hold, obs_d_hold;
  logic        obs_stall   [MAX_K];

  task automatic drive_txn(input bit r_if, input bit r_rd, input bit r_wr,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] wd);
    obs_en_n = 0; obs_if_k = -1; obs_d_k = -1; obs_if_n = 0; obs_d_n = 0;
    obs_len = 0; obs_if_data = 'x; obs_d_data = 'x;
    @(negedge clock);
    bus.ifReq = r_if; bus.ifAddr = ia;
    bus.dReadReq = r_rd; bus.dWriteReq = r_wr; bus.dAddr = da;
    bus.dWriteData = wd;
    for (int k = 0; k < MAX_K; k++) begin
      if (k > 0) begin
        @(negedge clock);
        if (obs_if_n > 0) bus.ifReq = 1'b0;
        if (obs_d_n > 0) begin bus.dReadReq = 1'b0; bus.dWriteReq = 1'b0; end
      end
      #1;
      obs_stall[k] = bus.stallF;
      obs_len      = k + 1;
      if (bus.memEn) begin
        if (obs_en_n < 4) begin
          obs_en_k[obs_en_n]    = k;
          obs_en_addr[obs_en_n] = bus.memAddr;
          obs_en_we[obs_en_n]   = bus.memWe;
          obs_en_wd[obs_en_n]   = bus.memWData;
        end
        obs_en_n++;
      end
      if (bus.ifAck) begin
        if (obs_if_n == 0) begin obs_if_k = k; obs_if_data = bus.ifData; end
        obs_if_n++;
      end
      if (bus.dAck) begin
        if (obs_d_n == 0) begin obs_d_k = k; obs_d_data = bus.dReadData; end
        obs_d_n++;
      end
      if ((!r_if || obs_if_n > 0) && (!(r_rd || r_wr) || obs_d_n > 0)) break;
    end
    // Cycle after the final ack: release and look for stray activity.
    @(negedge clock);
    bus.ifReq = 1'b0; bus.dReadReq = 1'b0; bus.dWriteReq = 1'b0;
    #1;
    if (bus.ifAck) obs_if_n++;
    if (bus.dAck)  obs_d_n++;
    if (bus.memEn) obs_en_n++;
    obs_if_hold = bus.ifData;
    obs_d_hold  = bus.dReadData;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.ifReq = 1'b0; bus.dReadReq = 1'b0; bus.dWriteReq = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [4*32+5-1:0] v;
    reset = 1'b1;
    bus.ifReq = 1'b1; bus.dReadReq = 1'b1; bus.dWriteReq = 1'b0;
    bus.ifAddr = 32'h4; bus.dAddr = 32'h8; bus.dWriteData = 32'h0;
    repeat (3) @(negedge clock);
    #1;
    v = {bus.memEn, bus.memWe, bus.memAddr, bus.memWData, bus.ifAck,
         bus.dAck, bus.ifData, bus.dReadData, bus.stallF};
    n_cmp++;
    if (v !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", v);
    end
    n_cmp++;
    if (bus.stallF !== 1'b0) begin
      n_err++;
      $display("FAIL reset_stall_forced: got %b want 0", bus.stallF);
    end
    @(negedge clock);
    bus.ifReq = 1'b0; bus.dReadReq = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (bus.memEn !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_command: memEn got %b want 0", bus.memEn);
    end
  endtask

  task automatic test_fetch_read();
    model_txn(1, 0, 0, 32'h40, 32'h0, 32'h0);
    drive_txn(1, 0, 0, 32'h40, 32'h0, 32'h0);
    n_cmp++;
    if (obs_en_k[0] !== 1 || obs_en_addr[0] !== 32'h40 || obs_en_we[0] !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_cmd: got k=%0d addr=%h we=%b want k=1 addr=40 we=0",
               obs_en_k[0], obs_en_addr[0], obs_en_we[0]);
    end
    n_cmp++;
    if (obs_if_k !== m_if_k) begin
      n_err++;
      $display("FAIL fetch_ack_cycle: got %0d want %0d", obs_if_k, m_if_k);
    end
    n_cmp++;
    if (obs_if_data !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL fetch_data: got %h want deadbeef", obs_if_data);
    end
    n_cmp++;
    if (obs_d_n !== 0 || obs_en_n !== 1 || obs_if_n !== 1) begin
      n_err++;
      $display("FAIL fetch_counts: got dAck=%0d memEn=%0d ifAck=%0d want 0/1/1",
               obs_d_n, obs_en_n, obs_if_n);
    end
    for (int k = 0; k < obs_len; k++) begin
      n_cmp++;
      if (obs_stall[k] !== (k < m_last_k)) begin
        n_err++;
        $display("FAIL fetch_stall k=%0d: got %b want %b", k, obs_stall[k], (k < m_last_k));
      end
    end
  endtask

  task automatic test_store();
    model_txn(0, 0, 1, 32'h0, 32'h100, 32'h12345678);
    drive_txn(0, 0, 1, 32'h0, 32'h100, 32'h12345678);
    n_cmp++;
    if (obs_en_k[0] !== 1 || obs_en_we[0] !== 1'b1 || obs_en_addr[0] !== 32'h100 ||
        obs_en_wd[0] !== 32'h12345678) begin
      n_err++;
      $display("FAIL store_cmd: got k=%0d we=%b addr=%h wd=%h want k=1 we=1 addr=100 wd=12345678",
               obs_en_k[0], obs_en_we[0], obs_en_addr[0], obs_en_wd[0]);
    end
    n_cmp++;
    if (obs_d_k !== m_d_k || obs_d_n !== 1 || obs_en_n !== 1) begin
      n_err++;
      $display("FAIL store_ack: got k=%0d n=%0d memEn=%0d want k=%0d n=1 memEn=1",
               obs_d_k, obs_d_n, obs_en_n, m_d_k);
    end
    for (int k = 0; k < obs_len; k++) begin
      n_cmp++;
      if (obs_stall[k] !== (k < m_last_k)) begin
        n_err++;
        $display("FAIL store_stall k=%0d: got %b want %b", k, obs_stall[k], (k < m_last_k));
      end
    end
    model_txn(0, 1, 0, 32'h0, 32'h100, 32'h0);
    drive_txn(0, 1, 0, 32'h0, 32'h100, 32'h0);
    n_cmp++;
    if (obs_d_data !== 32'h12345678 || obs_d_k !== m_d_k) begin
      n_err++;
      $display("FAIL store_readback: got %h at k=%0d want 12345678 at k=%0d",
               obs_d_data, obs_d_k, m_d_k);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    for (int rep = 0; rep < 2; rep++) begin
      model_txn(1, 1, 0, 32'h80 + 32'(rep * 4), 32'hC0 + 32'(rep * 4), 32'h0);
      drive_txn(1, 1, 0, 32'h80 + 32'(rep * 4), 32'hC0 + 32'(rep * 4), 32'h0);
      n_cmp++;
      if (obs_if_k !== m_if_k || obs_d_k !== m_d_k) begin
        n_err++;
        $display("FAIL contention%0d_order: got ifAck=%0d dAck=%0d want ifAck=%0d dAck=%0d",
                 rep, obs_if_k, obs_d_k, m_if_k, m_d_k);
      end
      n_cmp++;
      if (obs_en_n !== 2 || obs_en_k[1] !== m_en_k[1] ||
          obs_en_addr[0] !== m_en_addr[0] || obs_en_addr[1] !== m_en_addr[1]) begin
        n_err++;
        $display("FAIL contention%0d_cmds: got n=%0d k1=%0d a0=%h a1=%h want n=2 k1=%0d a0=%h a1=%h",
                 rep, obs_en_n, obs_en_k[1], obs_en_addr[0], obs_en_addr[1],
                 m_en_k[1], m_en_addr[0], m_en_addr[1]);
      end
      n_cmp++;
      if (obs_if_data !== m_if_data || obs_d_data !== m_d_data) begin
        n_err++;
        $display("FAIL contention%0d_data: got if=%h d=%h want if=%h d=%h",
                 rep, obs_if_data, obs_d_data, m_if_data, m_d_data);
      end
      for (int k = 0; k < obs_len; k++) begin
        n_cmp++;
        if (obs_stall[k] !== (k < m_last_k)) begin
          n_err++;
          $display("FAIL contention%0d_stall k=%0d: got %b want %b",
                   rep, k, obs_stall[k], (k < m_last_k));
        end
      end
    end
  endtask

  task automatic test_illegal_both();
    model_txn(0, 1, 1, 32'h0, 32'h200, 32'hA5A5_0F0F);
    drive_txn(0, 1, 1, 32'h0, 32'h200, 32'hA5A5_0F0F);
    n_cmp++;
    if (obs_en_n !== 1 || obs_en_we[0] !== 1'b1 || obs_en_wd[0] !== 32'hA5A5_0F0F) begin
      n_err++;
      $display("FAIL illegal_cmd: got n=%0d we=%b wd=%h want n=1 we=1 wd=a5a50f0f",
               obs_en_n, obs_en_we[0], obs_en_wd[0]);
    end
    n_cmp++;
    if (obs_d_n !== 1 || obs_d_k !== m_d_k) begin
      n_err++;
      $display("FAIL illegal_ack: got n=%0d k=%0d want n=1 k=%0d", obs_d_n, obs_d_k, m_d_k);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [4*32+5-1:0] v;
    int acks;
    @(negedge clock);
    bus.ifReq = 1'b1; bus.ifAddr = 32'h44;                 // cycle 0
    @(negedge clock);                                      // cycle 1: ISSUE
    @(negedge clock);                                      // cycle 2: WAIT
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.stallF !== 1'b0) begin
      n_err++;
      $display("FAIL rstwait_stall: got %b want 0", bus.stallF);
    end
    @(negedge clock);
    reset = 1'b0;
    bus.ifReq = 1'b0;
    model_reset();
    #1;
    v = {bus.memEn, bus.memWe, bus.memAddr, bus.memWData, bus.ifAck,
         bus.dAck, bus.ifData, bus.dReadData, bus.stallF};
    n_cmp++;
    if (v !== '0) begin
      n_err++;
      $display("FAIL rstwait_outputs: got %h want 0", v);
    end
    acks = 0;
    repeat (L + 4) begin
      @(negedge clock);
      #1;
      if (bus.ifAck || bus.dAck || bus.memEn) acks++;
    end
    n_cmp++;
    if (acks !== 0) begin
      n_err++;
      $display("FAIL rstwait_no_ack: got %0d ack/command cycles want 0", acks);
    end
    model_txn(1, 0, 0, 32'h48, 32'h0, 32'h0);
    drive_txn(1, 0, 0, 32'h48, 32'h0, 32'h0);
    n_cmp++;
    if (obs_if_k !== m_if_k || obs_if_data !== m_if_data) begin
      n_err++;
      $display("FAIL rstwait_fresh: got k=%0d data=%h want k=%0d data=%h",
               obs_if_k, obs_if_data, m_if_k, m_if_data);
    end
  endtask

  task automatic test_random();
    int          kind;
    bit          r_if, r_rd, r_wr;
    logic [31:0] ia, da, wd;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 5);
      r_if = (kind == 0) || (kind == 3) || (kind == 4);
      r_rd = (kind == 1) || (kind == 3) || (kind == 5);
      r_wr = (kind == 2) || (kind == 4) || (kind == 5);
      ia   = {22'd0, 8'($urandom_range(0, 31)), 2'b00};
      da   = {22'd0, 8'($urandom_range(0, 31)), 2'b00};
      wd   = $urandom();
      repeat ($urandom_range(0, 2)) @(negedge clock);
      model_txn(r_if, r_rd, r_wr, ia, da, wd);
      drive_txn(r_if, r_rd, r_wr, ia, da, wd);
      n_cmp++;
      if (obs_if_k !== m_if_k || obs_d_k !== m_d_k) begin
        n_err++;
        $display("FAIL rand%0d_ack: kind=%0d got if=%0d d=%0d want if=%0d d=%0d",
                 t, kind, obs_if_k, obs_d_k, m_if_k, m_d_k);
      end
      n_cmp++;
      if (obs_if_n !== int'(r_if) || obs_d_n !== int'(r_rd | r_wr) || obs_en_n !== m_en_n) begin
        n_err++;
        $display("FAIL rand%0d_counts: got if=%0d d=%0d en=%0d want if=%0d d=%0d en=%0d",
                 t, obs_if_n, obs_d_n, obs_en_n, r_if, r_rd | r_wr, m_en_n);
      end
      for (int g = 0; g < m_en_n; g++) begin
        n_cmp++;
        if (obs_en_k[g] !== m_en_k[g] || obs_en_addr[g] !== m_en_addr[g] ||
            obs_en_we[g] !== m_en_we[g] || (m_en_we[g] && obs_en_wd[g] !== m_en_wd[g])) begin
          n_err++;
          $display("FAIL rand%0d_cmd%0d: got k=%0d a=%h we=%b wd=%h want k=%0d a=%h we=%b wd=%h",
                   t, g, obs_en_k[g], obs_en_addr[g], obs_en_we[g], obs_en_wd[g],
                   m_en_k[g], m_en_addr[g], m_en_we[g], m_en_wd[g]);
        end
      end
      if (r_if) begin
        n_cmp++;
        if (obs_if_data !== m_if_data) begin
          n_err++;
          $display("FAIL rand%0d_ifdata: got %h want %h", t, obs_if_data, m_if_data);
        end
      end
      if (r_rd && !r_wr) begin
        n_cmp++;
        if (obs_d_data !== m_d_data) begin
          n_err++;
          $display("FAIL rand%0d_ddata: got %h want %h", t, obs_d_data, m_d_data);
        end
      end
      n_cmp++;
      if (obs_if_hold !== m_if_data || obs_d_hold !== m_d_data) begin
        n_err++;
        $display("FAIL rand%0d_hold: got if=%h d=%h want if=%h d=%h",
                 t, obs_if_hold, obs_d_hold, m_if_data, m_d_data);
      end
      for (int k = 0; k < obs_len; k++) begin
        n_cmp++;
        if (obs_stall[k] !== (k < m_last_k)) begin
          n_err++;
          $display("FAIL rand%0d_stall k=%0d: got %b want %b", t, k, obs_stall[k], (k < m_last_k));
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.ifReq = 1'b0; bus.ifAddr = '0;
    bus.dReadReq = 1'b0; bus.dWriteReq = 1'b0;
    bus.dAddr = '0; bus.dWriteData = '0;
    model_reset();
    test_reset();
    test_fetch_read();
    test_store();
    test_contention();
    test_illegal_both();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
